cmos_pattern_gen: RTL and testbench

- Synthetic DVP camera source. Emits cmos-style vsync/href/16-bit RGB565 pixel streams with the same timing shape as the OV5640 feeds consumed by the dual-camera combiner.
- Stands in for either camera during bring-up. The combiner, FIFOs and splicing path can then be exercised with known, deterministic pixels and line/frame counts.
- Drives one camera-input port group of the combiner, clocked by that camera's pclk.

---
 rtl/cmos_pkg.sv | 42 ++++
 rtl/cmos_pattern_pix.sv | 27 ++
 rtl/cmos_pattern_gen.sv | 165 ++++++++++++++++
 tb/tb_cmos_pattern_gen.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmos_pkg.sv
// Shared definitions for the synthetic DVP camera source: RGB565 bar colours,
// pattern_sel encodings and the frame-timing FSM states.
package cmos_pkg;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_RAMP  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_SOLID = 2'd3
    } pattern_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_VS   = 3'd1,
        ST_VBP  = 3'd2,
        ST_ACT  = 3'd3,
        ST_VFP  = 3'd4
    } state_e;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return RGB_WHITE;
            3'd1:    return RGB_YELLOW;
            3'd2:    return RGB_CYAN;
            3'd3:    return RGB_GREEN;
            3'd4:    return RGB_MAGENTA;
            3'd5:    return RGB_RED;
            3'd6:    return RGB_BLUE;
            default: return RGB_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/cmos_pattern_pix.sv
// Combinational pixel generator: maps (mode, x, y, bar index, solid colour)
// to one RGB565 value. The parent registers the result.
module cmos_pattern_pix
    import cmos_pkg::*;
#(
    parameter int CHECK_SHIFT = 5
) (
    input  pattern_e    mode,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [2:0]  bar,
    input  logic [15:0] solid,
    output logic [15:0] pix
);

    always_comb begin
        pix = RGB_BLACK;
        case (mode)
            PAT_BARS:  pix = bar_color(bar);
            PAT_RAMP:  pix = x + y;
            PAT_CHECK: pix = (x[CHECK_SHIFT] ^ y[CHECK_SHIFT]) ? RGB_WHITE : RGB_BLACK;
            PAT_SOLID: pix = solid;
            default:   pix = RGB_BLACK;
        endcase
    end

endmodule

// File: rtl/cmos_pattern_gen.sv
// Synthetic OV5640-style DVP source: vsync/href/RGB565 frames with
// deterministic test patterns, always completing whole frames.
module cmos_pattern_gen
    import cmos_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int H_BLANK     = 160,
    parameter int V_ACTIVE    = 360,
    parameter int VS_LINES    = 4,
    parameter int VBP_LINES   = 8,
    parameter int VFP_LINES   = 4,
    parameter int CHECK_SHIFT = 5
) (
    input  logic        cmos_pclk,
    input  logic        sys_rst_n,
    input  logic        gen_en,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_color,
    output logic        cmos_vsync,
    output logic        cmos_href,
    output logic [15:0] cmos_data,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    localparam int L     = H_ACTIVE + H_BLANK;
    localparam int H_W   = $clog2(L + 1);
    localparam int MAX_A = (VS_LINES > VBP_LINES) ? VS_LINES : VBP_LINES;
    localparam int MAX_B = (V_ACTIVE > VFP_LINES) ? V_ACTIVE : VFP_LINES;
    localparam int MAXL  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int LN_W  = $clog2(MAXL + 1);
    localparam int BW    = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam int BC_W  = $clog2(BW + 1);

    localparam logic [H_W-1:0]  H_LAST    = H_W'(L - 1);
    localparam logic [H_W-1:0]  H_ACT_END = H_W'(H_ACTIVE);
    localparam logic [LN_W-1:0] VS_LAST   = LN_W'(VS_LINES - 1);
    localparam logic [LN_W-1:0] VBP_LAST  = LN_W'(VBP_LINES - 1);
    localparam logic [LN_W-1:0] VA_LAST   = LN_W'(V_ACTIVE - 1);
    localparam logic [LN_W-1:0] VFP_LAST  = LN_W'(VFP_LINES - 1);
    localparam logic [BC_W-1:0] BW_LAST   = BC_W'(BW - 1);

    state_e          st_q, st_nxt;
    logic [H_W-1:0]  h_q, h_nxt;
    logic [LN_W-1:0] ln_q, ln_nxt, ln_last;
    logic [2:0]      bar_q, bar_nxt;
    logic [BC_W-1:0] bc_q, bc_nxt;
    pattern_e        sel_q;
    logic [15:0]     solid_q;
    logic            latch, frame_done, href_nxt;
    logic [15:0]     pix;

    // Next state and counters; outputs are registered from these so each
    // output cycle matches the state held in that same cycle.
    always_comb begin
        st_nxt     = st_q;
        h_nxt      = h_q;
        ln_nxt     = ln_q;
        latch      = 1'b0;
        frame_done = 1'b0;
        case (st_q)
            ST_VS:   ln_last = VS_LAST;
            ST_VBP:  ln_last = VBP_LAST;
            ST_ACT:  ln_last = VA_LAST;
            default: ln_last = VFP_LAST;
        endcase

        if (st_q == ST_IDLE) begin
            if (gen_en) begin
                st_nxt = ST_VS;
                h_nxt  = '0;
                ln_nxt = '0;
                latch  = 1'b1;
            end
        end else if (h_q != H_LAST) begin
            h_nxt = h_q + H_W'(1);
        end else begin
            h_nxt = '0;
            if (ln_q != ln_last) begin
                ln_nxt = ln_q + LN_W'(1);
            end else begin
                ln_nxt = '0;
                case (st_q)
                    ST_VS:   st_nxt = ST_VBP;
                    ST_VBP:  st_nxt = ST_ACT;
                    ST_ACT:  st_nxt = ST_VFP;
                    default: begin
                        frame_done = 1'b1;
                        if (gen_en) begin
                            st_nxt = ST_VS;
                            latch  = 1'b1;
                        end else begin
                            st_nxt = ST_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    // Bar index tracks h_cnt by compare-and-advance; trailing remainder stays on bar 7.
    always_comb begin
        bar_nxt = bar_q;
        bc_nxt  = bc_q;
        if (h_nxt == '0) begin
            bar_nxt = 3'd0;
            bc_nxt  = '0;
        end else if (bar_q != 3'd7) begin
            if (bc_q == BW_LAST) begin
                bar_nxt = bar_q + 3'd1;
                bc_nxt  = '0;
            end else begin
                bc_nxt = bc_q + BC_W'(1);
            end
        end
    end

    assign href_nxt = (st_nxt == ST_ACT) && (h_nxt < H_ACT_END);

    cmos_pattern_pix #(
        .CHECK_SHIFT(CHECK_SHIFT)
    ) u_pix (
        .mode  (sel_q),
        .x     (16'(h_nxt)),
        .y     (16'(ln_nxt)),
        .bar   (bar_nxt),
        .solid (solid_q),
        .pix   (pix)
    );

    always_ff @(posedge cmos_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            st_q        <= ST_IDLE;
            h_q         <= '0;
            ln_q        <= '0;
            bar_q       <= 3'd0;
            bc_q        <= '0;
            sel_q       <= PAT_BARS;
            solid_q     <= 16'h0000;
            cmos_vsync  <= 1'b0;
            cmos_href   <= 1'b0;
            cmos_data   <= 16'h0000;
            frame_start <= 1'b0;
            frame_cnt   <= 16'h0000;
        end else begin
            st_q  <= st_nxt;
            h_q   <= h_nxt;
            ln_q  <= ln_nxt;
            bar_q <= bar_nxt;
            bc_q  <= bc_nxt;
            if (latch) begin
                sel_q   <= pattern_e'(pattern_sel);
                solid_q <= solid_color;
            end
            cmos_vsync  <= (st_nxt == ST_VS);
            cmos_href   <= href_nxt;
            cmos_data   <= href_nxt ? pix : 16'h0000;
            frame_start <= (st_nxt == ST_VS) && (h_nxt == '0) && (ln_nxt == '0);
            if (frame_done) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_cmos_pattern_gen.sv
// Bench for cmos_pattern_gen with reduced frame geometry; a frame-position
// reference model predicts every output cycle alongside directed checks.
module tb_cmos_pattern_gen;

    localparam int HA   = 20;
    localparam int HB   = 6;
    localparam int VA   = 40;
    localparam int VSL  = 2;
    localparam int VBPL = 3;
    localparam int VFPL = 2;
    localparam int CS   = 2;
    localparam int L    = HA + HB;
    localparam int F    = (VSL + VBPL + VA + VFPL) * L;
    localparam int BW   = HA / 8;
    localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    logic        cmos_pclk   = 1'b0;
    logic        sys_rst_n   = 1'b0;
    logic        gen_en      = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [15:0] solid_color = 16'h0000;
    logic        cmos_vsync, cmos_href, frame_start;
    logic [15:0] cmos_data, frame_cnt;

    cmos_pattern_gen #(
        .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .VS_LINES(VSL),
        .VBP_LINES(VBPL), .VFP_LINES(VFPL), .CHECK_SHIFT(CS)
    ) dut (
        .cmos_pclk   (cmos_pclk),
        .sys_rst_n   (sys_rst_n),
        .gen_en      (gen_en),
        .pattern_sel (pattern_sel),
        .solid_color (solid_color),
        .cmos_vsync  (cmos_vsync),
        .cmos_href   (cmos_href),
        .cmos_data   (cmos_data),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt)
    );

    always #5 cmos_pclk = ~cmos_pclk;

    int tests = 0;
    int fails = 0;

    // Reference model: running flag plus flat position inside the frame.
    bit          m_run  = 1'b0;
    int          m_p    = 0;
    int          m_sel  = 0;
    logic [15:0] m_solid = 16'h0;
    logic [15:0] m_fcnt  = 16'h0;

    // Stream monitor statistics.
    int vs_len, fs_cnt, rises, hcyc, len_bad, gap_bad, vbp_gap, vbp_cnt, blank_nz;
    int mon_x, mon_y, hlen, gap;
    bit vbp_on, have_fall;
    logic p_vs = 1'b0, p_href = 1'b0;
    logic [15:0] fb [VA][HA];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [34:0] model_out();
        int line, h, x, y, b;
        logic vs, hr, fs;
        logic [15:0] d;
        vs = 1'b0; hr = 1'b0; fs = 1'b0; d = 16'h0;
        if (m_run) begin
            line = m_p / L;
            h    = m_p % L;
            vs   = (line < VSL);
            fs   = (m_p == 0);
            if (line >= VSL + VBPL && line < VSL + VBPL + VA && h < HA) begin
                hr = 1'b1;
                x  = h;
                y  = line - VSL - VBPL;
                case (m_sel)
                    0: begin
                        b = x / BW;
                        if (b > 7) b = 7;
                        d = BARS[b];
                    end
                    1: d = 16'(x + y);
                    2: d = ((((x >> CS) ^ (y >> CS)) & 1) != 0) ? 16'hFFFF : 16'h0000;
                    default: d = m_solid;
                endcase
            end
        end
        return {vs, hr, fs, d, m_fcnt};
    endfunction

    task automatic model_edge();
        if (m_run) begin
            if (m_p == F - 1) begin
                m_fcnt++;
                m_p = 0;
                if (gen_en) begin
                    m_sel = int'(pattern_sel); m_solid = solid_color;
                end else begin
                    m_run = 1'b0;
                end
            end else begin
                m_p++;
            end
        end else if (gen_en) begin
            m_run = 1'b1; m_p = 0;
            m_sel = int'(pattern_sel); m_solid = solid_color;
        end
    endtask

    task automatic clear_stats();
        vs_len = 0; fs_cnt = 0; rises = 0; hcyc = 0; len_bad = 0; gap_bad = 0;
        vbp_gap = -1; vbp_cnt = 0; blank_nz = 0; vbp_on = 1'b0; have_fall = 1'b0;
        mon_x = 0; mon_y = 0; hlen = 0; gap = 0;
    endtask

    task automatic monitor();
        if (cmos_vsync && !p_vs) begin
            mon_y = 0; have_fall = 1'b0;
        end
        if (cmos_vsync) vs_len++;
        if (frame_start) fs_cnt++;
        if (p_vs && !cmos_vsync) begin
            vbp_on = 1'b1; vbp_cnt = 0;
        end
        if (vbp_on) begin
            if (cmos_href) begin
                vbp_on = 1'b0;
                if (vbp_gap < 0) vbp_gap = vbp_cnt;
            end else begin
                vbp_cnt++;
            end
        end
        if (cmos_href) begin
            if (!p_href) begin
                rises++; hlen = 0; mon_x = 0;
                if (have_fall && gap != HB) gap_bad++;
            end
            hlen++; hcyc++;
            if (mon_y < VA && mon_x < HA) fb[mon_y][mon_x] = cmos_data;
            mon_x++;
        end else begin
            if (cmos_data != 16'h0) blank_nz++;
            if (p_href) begin
                if (hlen != HA) len_bad++;
                mon_y++; gap = 1; have_fall = 1'b1;
            end else begin
                gap++;
            end
        end
        p_vs   = cmos_vsync;
        p_href = cmos_href;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge cmos_pclk);
            if (sys_rst_n) model_edge();
            #1;
            check("cycle", {cmos_vsync, cmos_href, frame_start, cmos_data, frame_cnt}, model_out());
            monitor();
        end
    endtask

    task automatic run_to_frame_end(input int budget);
        int k = 0;
        while (!(m_run && m_p == F - 1) && k < budget) begin
            step(1);
            k++;
        end
        check("frame_end_reached", 64'(m_run && m_p == F - 1), 64'd1);
    endtask

    initial begin
        int a, k;
        clear_stats();
        repeat (3) @(negedge cmos_pclk);
        check("reset_outputs", {cmos_vsync, cmos_href, frame_start, cmos_data, frame_cnt}, 64'd0);
        @(negedge cmos_pclk);
        sys_rst_n = 1'b1;
        step(5);

        // Frame 1: colour bars, timing shape.
        pattern_sel = 2'd0;
        gen_en = 1'b1;
        clear_stats();
        step(F);
        check("vsync_len", vs_len, VSL * L);
        check("frame_start_pulses", fs_cnt, 1);
        check("href_pulses", rises, VA);
        check("href_cycles", hcyc, VA * HA);
        check("href_len_bad", len_bad, 0);
        check("href_gap_bad", gap_bad, 0);
        check("vbp_gap", vbp_gap, VBPL * L);
        check("blank_data_nonzero", blank_nz, 0);
        check("fcnt_before_end", frame_cnt, 0);
        for (int b = 0; b < 8; b++) check($sformatf("bar%0d", b), fb[0][b * BW], BARS[b]);
        check("bar1_last_px", fb[0][2 * BW - 1], BARS[1]);
        check("bar_remainder", fb[0][HA - 1], BARS[7]);
        step(1);
        check("fcnt_after_frame", frame_cnt, 1);
        check("vsync_back_to_back", {cmos_vsync, frame_start}, 2'b11);

        // Pattern change mid-frame takes effect next frame only.
        step(F / 2);
        pattern_sel = 2'd3;
        solid_color = 16'h1234;
        run_to_frame_end(F);
        check("midchange_still_bars", fb[VA - 1][0], 16'hFFFF);
        step(F);
        check("solid_first_px", fb[0][0], 16'h1234);
        check("solid_last_px", fb[VA - 1][HA - 1], 16'h1234);

        // Ramp.
        pattern_sel = 2'd1;
        clear_stats();
        step(F);
        check("ramp_x10_y3", fb[3][10], 16'h000D);
        check("ramp_blank_zero", blank_nz, 0);
        check("ramp_href_pulses", rises, VA);

        // Checker.
        pattern_sel = 2'd2;
        step(F);
        check("check_x3_y0", fb[0][3], 16'h0000);
        check("check_x4_y0", fb[0][4], 16'hFFFF);
        check("check_x4_y4", fb[4][4], 16'h0000);

        // Randomized mode, colour and run-request traffic.
        for (int r = 0; r < 8; r++) begin
            pattern_sel = 2'($urandom_range(0, 3));
            solid_color = 16'($urandom);
            gen_en      = ($urandom_range(0, 3) != 0);
            step($urandom_range(1, F));
        end

        // Deassert gen_en during active lines: the frame still completes.
        gen_en = 1'b1;
        run_to_frame_end(2 * F + 2);
        clear_stats();
        a = (VSL + VBPL + 5) * L + 7;
        step(1);
        step(a);
        gen_en = 1'b0;
        step(F - 1 - a);
        step(1);
        check("stop_href_pulses", rises, VA);
        check("stop_idle_outputs", {cmos_vsync, cmos_href, frame_start, cmos_data}, 64'd0);
        step(L);

        // Asynchronous reset in the middle of a line.
        gen_en = 1'b1;
        k = 0;
        while (cmos_href !== 1'b1 && k < 2 * F) begin
            step(1);
            k++;
        end
        check("href_seen_before_reset", cmos_href, 1);
        step(3);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {cmos_vsync, cmos_href, frame_start, cmos_data, frame_cnt}, 64'd0);
        m_run = 1'b0; m_p = 0; m_fcnt = 16'h0; m_sel = 0; m_solid = 16'h0;
        p_vs = 1'b0; p_href = 1'b0;
        repeat (2) @(negedge cmos_pclk);
        gen_en = 1'b0;
        sys_rst_n = 1'b1;
        step(3);
        gen_en = 1'b1;
        step(1);
        check("restart_vsync_fs", {cmos_vsync, frame_start}, 2'b11);
        check("restart_fcnt", frame_cnt, 0);
        step(L);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
